decode_queue: RTL and testbench
===============================

# decode_queue

Parametrised decode stage that accepts raw fetched instruction words with their PC, decodes them (RV32I, plus optional RV32C expansion), and buffers the decoded records in a DEPTH-entry FIFO. It sits between the instruction fetcher and issue/dispatch, and decouples the two with valid/ready handshakes. It also provides a flush for branch mispredicts. Beyond plain decode, it adds compressed-instruction support and register-field sanitising for branches and stores.

## Interface
- DEPTH, 4, FIFO entries; power of two, at least 2.
- C_EXT, 1, 1 enables RV32C expansion; 0 treats 16-bit encodings as illegal.

- clk_in  input  1  clock; all state changes on the rising edge.
- rst_n_in  input  1  reset, asynchronous, active-low.
- rdy_in  input  1  global enable; when low, the block is frozen.
- flush_in  input  1  discard all buffered entries.
- in_valid  input  1  fetcher offers in_code/in_pc.
- in_ready  output  1  block can accept this cycle; equals !full && rdy_in.
- in_code  input  32  instruction word; a compressed instruction occupies bits 15:0.
- in_pc  input  32  PC of in_code.
- out_valid  output  1  head entry valid; equals !empty && rdy_in.
- out_ready  input  1  consumer takes the head.
- out_type  output  `OPE_WIDTH  decoded operation code from define.v; `EMPTY_INS if illegal.
- out_rd, out_rs1, out_rs2  output  `EX_REG_NUMBER_WIDTH  register indices; `REG_NUMBER (32) means unused.
- out_imm  output  32  fully sign/zero-extended immediate.
- out_pc  output  32  PC of the head entry.
- out_is_c  output  1  head was compressed; fall-through PC is +2, otherwise +4.
- count  output  $clog2(DEPTH)+1  number of occupied entries.

## Operation
- **Push:** occurs when in_valid && in_ready and flush_in is low. The decoded record {type, rd, rs1, rs2, imm, pc, is_c} is written at the tail.
- **Pop:** occurs when out_valid && out_ready and flush_in is low. The head advances.
- **Decode:** combinational on in_code before the write; stored entries are never re-decoded.
- **Compressed detection:** an instruction is compressed iff in_code[1:0] != 2'b11.
  - C_EXT=1: expand to the RV32I equivalent, then decode. Full integer RV32C is covered: C.ADDI4SPN, C.LW, C.SW, C.NOP/ADDI, C.JAL, C.LI, C.ADDI16SP, C.LUI, C.SRLI/SRAI/ANDI, C.SUB/XOR/OR/AND, C.J, C.BEQZ/BNEZ, C.SLLI, C.LWSP, C.SWSP, C.JR, C.JALR, C.MV, C.ADD.
  - C_EXT=0: the result is `EMPTY_INS.
  - Reserved or illegal encodings, including an all-zero 16-bit word, produce `EMPTY_INS, with rd/rs1/rs2 = 32 and imm = 0.
- **Register sanitising:**
  - Unused source fields are 32.
  - Branches and stores have rd = 32.
  - LUI/AUIPC/JAL have rs1 = rs2 = 32.
  - I-type ALU ops, loads and JALR have rs2 = 32.
  - rd = x0 is kept as 0; no write suppression happens here.
- **Immediates:**
  - Shift-immediate instructions carry the 5-bit shamt, zero-extended.
  - SRAI vs SRLI is selected by bit 30.
  - All other immediates are sign-extended per RV32I format.
- **Priority:** reset > flush_in > !rdy_in > push/pop.
  - flush_in: the next state is empty; any same-cycle push or pop is discarded.
  - rdy_in low: pointers, count and contents hold; in_ready = out_valid = 0.
- **Simultaneous push and pop** when not empty and not full: count is unchanged and both pointers advance.
- **When full:** in_ready = 0 even if a pop occurs in the same cycle; there is no full-bypass.
- **When empty:** out_valid = 0; the out_* data fields show the stale head and must not be used.
- **Pointer width:** pointers are $clog2(DEPTH) bits and wrap naturally. count reaches exactly DEPTH when full.

## Timing
- Latency: an instruction pushed in cycle N is visible with out_valid in cycle N+1; there is no combinational in-to-out path.
- out_* fields are driven from the head register and are stable while out_valid && !out_ready.
- Asynchronous reset: count = 0, pointers = 0, in_ready = 0 during reset (rdy_in does not matter), out_valid = 0, out_type = `EMPTY_INS, all other out_* = 0.
- Reset asserted mid-operation clears the block immediately, without waiting for a clock. The first push is possible in the first edge after deassertion.
- Flush in cycle N: count = 0 and out_valid = 0 from cycle N+1.

## Structure
- Operation codes, `REG_NUMBER, `EMPTY_INS and the width macros come from the shared define.v; no local redefinition.
- Add opcode constants (7'h37, 7'h63, …) and a DECODED_WIDTH macro for the packed FIFO record to define.v.
- Sub-module rvc_expand: purely combinational, 16-bit input to 32-bit RV32I output plus an illegal flag. It is instantiated only under C_EXT. The RV32I decode lives in decode_queue itself.

## Test plan
- **RV32I I-type:** push 0x00500093 (addi x1,x0,5) at pc 0x100 with out_ready=1. Next cycle: out_valid=1, ADDI, rd=1, rs1=0, rs2=32, imm=5, out_pc=0x100, out_is_c=0.
- **Shift and compressed:** push 0x40335293, then 0x0000557D.
  - First entry: SRAI, rd=5, rs1=6, imm=3.
  - Second entry: ADDI, rd=10, rs1=0, rs2=32, imm=0xFFFFFFFF, is_c=1.
  - With C_EXT=0, the second entry decodes to `EMPTY_INS.
- **Fill and drain:** with out_ready=0, push 4 words.
  - count=4, in_ready=0; a 5th word is not accepted.
  - Then set out_ready=1: the words come out in order, with count going 3, 2, 1, 0.
- **Flush precedence:** with count=3, assert flush_in together with in_valid and out_ready. Next cycle: count=0, out_valid=0, and the pushed word is lost.
- **Freeze and reset:**
  - rdy_in=0 with in_valid=out_ready=1: count and head are unchanged.
  - Assert rst_n_in low between edges with count=2: count=0 and out_valid=0 before the next edge.
- **Branch/store sanitising:**
  - 0x00208463 (beq x1,x2,8): BEQ, rd=32, rs1=1, rs2=2, imm=8.
  - 0x0020A223 (sw x2,4(x1)): SW, rd=32, imm=4.

Source files
------------

// File: rtl/decode_queue_pkg.sv
// Shared decode definitions: operation codes, register sentinel, opcode
// constants, the packed FIFO record and small RV32I encoding helpers.
package decode_queue_pkg;

  localparam int OPE_WIDTH           = 6;
  localparam int EX_REG_NUMBER_WIDTH = 6;
  localparam logic [EX_REG_NUMBER_WIDTH-1:0] REG_NUMBER = 6'd32;

  typedef enum logic [OPE_WIDTH-1:0] {
    EMPTY_INS,
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_SB, OP_SH, OP_SW,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
    OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA,
    OP_OR, OP_AND,
    OP_FENCE, OP_ECALL, OP_EBREAK
  } op_e;

  localparam logic [6:0] OPC_LUI     = 7'h37;
  localparam logic [6:0] OPC_AUIPC   = 7'h17;
  localparam logic [6:0] OPC_JAL     = 7'h6f;
  localparam logic [6:0] OPC_JALR    = 7'h67;
  localparam logic [6:0] OPC_BRANCH  = 7'h63;
  localparam logic [6:0] OPC_LOAD    = 7'h03;
  localparam logic [6:0] OPC_STORE   = 7'h23;
  localparam logic [6:0] OPC_OPIMM   = 7'h13;
  localparam logic [6:0] OPC_OP      = 7'h33;
  localparam logic [6:0] OPC_MISCMEM = 7'h0f;
  localparam logic [6:0] OPC_SYSTEM  = 7'h73;

  typedef struct packed {
    op_e                            op;
    logic [EX_REG_NUMBER_WIDTH-1:0] rd;
    logic [EX_REG_NUMBER_WIDTH-1:0] rs1;
    logic [EX_REG_NUMBER_WIDTH-1:0] rs2;
    logic [31:0]                    imm;
    logic [31:0]                    pc;
    logic                           is_c;
  } decoded_t;

  localparam int DECODED_WIDTH = $bits(decoded_t);

  localparam decoded_t RESET_REC = '{EMPTY_INS, 6'd0, 6'd0, 6'd0, 32'd0, 32'd0, 1'b0};

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:1] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:1] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OPC_OP};
  endfunction

endpackage

// File: rtl/rvc_expand.sv
// Combinational RV32C to RV32I expander; flags reserved/illegal encodings.
module rvc_expand
  import decode_queue_pkg::*;
(
  input  logic [15:0] c_i,
  output logic [31:0] instr_o,
  output logic        illegal_o
);

  logic [4:0]  rd, rs2, rdp, rs1p;
  logic [11:0] imm6_sx;
  logic [9:0]  spn_imm, a16_imm;
  logic [6:0]  lw_imm;
  logic [7:0]  lwsp_imm, swsp_imm;
  logic [11:1] j_off;
  logic [8:1]  b_off;

  assign rd       = c_i[11:7];
  assign rs2      = c_i[6:2];
  assign rdp      = {2'b01, c_i[4:2]};
  assign rs1p     = {2'b01, c_i[9:7]};
  assign imm6_sx  = {{7{c_i[12]}}, c_i[6:2]};
  assign spn_imm  = {c_i[10:7], c_i[12:11], c_i[5], c_i[6], 2'b00};
  assign lw_imm   = {c_i[5], c_i[12:10], c_i[6], 2'b00};
  assign a16_imm  = {c_i[12], c_i[4:3], c_i[5], c_i[2], c_i[6], 4'b0000};
  assign lwsp_imm = {c_i[3:2], c_i[12], c_i[6:4], 2'b00};
  assign swsp_imm = {c_i[8:7], c_i[12:9], 2'b00};
  assign j_off    = {c_i[12], c_i[8], c_i[10:9], c_i[6], c_i[7], c_i[2], c_i[11], c_i[5:3]};
  assign b_off    = {c_i[12], c_i[6:5], c_i[2], c_i[11:10], c_i[4:3]};

  // Expansion table keyed on funct3 and quadrant.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    instr_o   = '0;
    illegal_o = 1'b0;
    case ({c_i[15:13], c_i[1:0]})
      5'b000_00: begin
        instr_o   = enc_i({2'b00, spn_imm}, 5'd2, 3'b000, rdp, OPC_OPIMM);
        illegal_o = (spn_imm == '0);
      end
      5'b010_00: instr_o = enc_i({5'b0, lw_imm}, rs1p, 3'b010, rdp, OPC_LOAD);
      5'b110_00: instr_o = enc_s({5'b0, lw_imm}, rdp, rs1p, 3'b010);
      5'b000_01: instr_o = enc_i(imm6_sx, rd, 3'b000, rd, OPC_OPIMM);
      5'b001_01: instr_o = enc_j({{9{j_off[11]}}, j_off}, 5'd1);
      5'b010_01: instr_o = enc_i(imm6_sx, 5'd0, 3'b000, rd, OPC_OPIMM);
      5'b011_01: begin
        if (rd == 5'd2) begin
          instr_o   = enc_i({{2{a16_imm[9]}}, a16_imm}, 5'd2, 3'b000, 5'd2, OPC_OPIMM);
          illegal_o = (a16_imm == '0);
        end else begin
          instr_o   = {{14{c_i[12]}}, c_i[12], c_i[6:2], rd, OPC_LUI};
          illegal_o = ({c_i[12], c_i[6:2]} == '0);
        end
      end
      5'b100_01: begin
        case (c_i[11:10])
          2'b00: instr_o = enc_i({7'b0000000, c_i[6:2]}, rs1p, 3'b101, rs1p, OPC_OPIMM);
          2'b01: instr_o = enc_i({7'b0100000, c_i[6:2]}, rs1p, 3'b101, rs1p, OPC_OPIMM);
          2'b10: instr_o = enc_i(imm6_sx, rs1p, 3'b111, rs1p, OPC_OPIMM);
          default: begin
            case (c_i[6:5])
              2'b00:   instr_o = enc_r(7'b0100000, rdp, rs1p, 3'b000, rs1p);
              2'b01:   instr_o = enc_r(7'b0000000, rdp, rs1p, 3'b100, rs1p);
              2'b10:   instr_o = enc_r(7'b0000000, rdp, rs1p, 3'b110, rs1p);
              default: instr_o = enc_r(7'b0000000, rdp, rs1p, 3'b111, rs1p);
            endcase
          end
        endcase
        // RV64-only shift amounts and register forms share these encodings.
        illegal_o = c_i[12] && (c_i[11:10] != 2'b10);
      end
      5'b101_01: instr_o = enc_j({{9{j_off[11]}}, j_off}, 5'd0);
      5'b110_01: instr_o = enc_b({{4{b_off[8]}}, b_off}, 5'd0, rs1p, 3'b000);
      5'b111_01: instr_o = enc_b({{4{b_off[8]}}, b_off}, 5'd0, rs1p, 3'b001);
      5'b000_10: begin
        instr_o   = enc_i({7'b0000000, c_i[6:2]}, rd, 3'b001, rd, OPC_OPIMM);
        illegal_o = c_i[12];
      end
      5'b010_10: begin
        instr_o   = enc_i({4'b0, lwsp_imm}, 5'd2, 3'b010, rd, OPC_LOAD);
        illegal_o = (rd == 5'd0);
      end
      5'b100_10: begin
        if (!c_i[12]) begin
          if (rs2 == 5'd0) begin
            instr_o   = enc_i(12'd0, rd, 3'b000, 5'd0, OPC_JALR);
            illegal_o = (rd == 5'd0);
          end else begin
            instr_o = enc_r(7'b0000000, rs2, 5'd0, 3'b000, rd);
          end
        end else if (rs2 == 5'd0) begin
          instr_o = (rd == 5'd0) ? 32'h0010_0073 : enc_i(12'd0, rd, 3'b000, 5'd1, OPC_JALR);
        end else begin
          instr_o = enc_r(7'b0000000, rs2, rd, 3'b000, rd);
        end
      end
      5'b110_10: instr_o = enc_s({4'b0, swsp_imm}, rs2, 5'd2, 3'b010);
      default:   illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_queue.sv
// Decode stage: decodes fetched RV32I/RV32C words and buffers the records in a FIFO.
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter bit C_EXT = 1'b1
) (
  input  logic                           clk_in,
  input  logic                           rst_n_in,
  input  logic                           rdy_in,
  input  logic                           flush_in,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [31:0]                    in_code,
  input  logic [31:0]                    in_pc,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [OPE_WIDTH-1:0]           out_type,
  output logic [EX_REG_NUMBER_WIDTH-1:0] out_rd,
  output logic [EX_REG_NUMBER_WIDTH-1:0] out_rs1,
  output logic [EX_REG_NUMBER_WIDTH-1:0] out_rs2,
  output logic [31:0]                    out_imm,
  output logic [31:0]                    out_pc,
  output logic                           out_is_c,
  output logic [$clog2(DEPTH):0]         count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0] exp_word, word;
  logic        exp_illegal, is_c, illegal;
  decoded_t    dec, head;

  assign is_c = (in_code[1:0] != 2'b11);

  if (C_EXT) begin : g_rvc
    rvc_expand u_rvc (.c_i(in_code[15:0]), .instr_o(exp_word), .illegal_o(exp_illegal));
  end else begin : g_no_rvc
    assign exp_word    = '0;
    assign exp_illegal = 1'b1;
  end

  assign word    = is_c ? exp_word : in_code;
  assign illegal = is_c && exp_illegal;

  logic [2:0] f3;
  logic [6:0] f7;
  assign f3 = word[14:12];
  assign f7 = word[31:25];

  // RV32I decode: pick the operation, then fill fields by format.
  always_comb begin
    dec.op   = EMPTY_INS;
    dec.rd   = REG_NUMBER;
    dec.rs1  = REG_NUMBER;
    dec.rs2  = REG_NUMBER;
    dec.imm  = '0;
    dec.pc   = in_pc;
    dec.is_c = is_c;
    if (!illegal) begin
      case (word[6:0])
        OPC_LUI:   dec.op = OP_LUI;
        OPC_AUIPC: dec.op = OP_AUIPC;
        OPC_JAL:   dec.op = OP_JAL;
        OPC_JALR:  if (f3 == 3'b000) dec.op = OP_JALR;
        OPC_BRANCH: begin
          case (f3)
            3'b000: dec.op = OP_BEQ;  3'b001: dec.op = OP_BNE;
            3'b100: dec.op = OP_BLT;  3'b101: dec.op = OP_BGE;
            3'b110: dec.op = OP_BLTU; 3'b111: dec.op = OP_BGEU;
            default: dec.op = EMPTY_INS;
          endcase
        end
        OPC_LOAD: begin
          case (f3)
            3'b000: dec.op = OP_LB;  3'b001: dec.op = OP_LH; 3'b010: dec.op = OP_LW;
            3'b100: dec.op = OP_LBU; 3'b101: dec.op = OP_LHU;
            default: dec.op = EMPTY_INS;
          endcase
        end
        OPC_STORE: begin
          case (f3)
            3'b000: dec.op = OP_SB; 3'b001: dec.op = OP_SH; 3'b010: dec.op = OP_SW;
            default: dec.op = EMPTY_INS;
          endcase
        end
        OPC_OPIMM: begin
          case (f3)
            3'b000: dec.op = OP_ADDI;  3'b010: dec.op = OP_SLTI;
            3'b011: dec.op = OP_SLTIU; 3'b100: dec.op = OP_XORI;
            3'b110: dec.op = OP_ORI;   3'b111: dec.op = OP_ANDI;
            3'b001: if (f7 == 7'b0) dec.op = OP_SLLI;
            default: if ({f7[6], f7[4:0]} == 6'b0) dec.op = word[30] ? OP_SRAI : OP_SRLI;
          endcase
        end
        OPC_OP: begin
          if (f7 == 7'b0000000) begin
            case (f3)
              3'b000: dec.op = OP_ADD;  3'b001: dec.op = OP_SLL;
              3'b010: dec.op = OP_SLT;  3'b011: dec.op = OP_SLTU;
              3'b100: dec.op = OP_XOR;  3'b101: dec.op = OP_SRL;
              3'b110: dec.op = OP_OR;   default: dec.op = OP_AND;
            endcase
          end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
            dec.op = OP_SUB;
          end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
            dec.op = OP_SRA;
          end
        end
        OPC_MISCMEM: if (f3 == 3'b000) dec.op = OP_FENCE;
        OPC_SYSTEM: begin
          if (word == 32'h0000_0073) dec.op = OP_ECALL;
          else if (word == 32'h0010_0073) dec.op = OP_EBREAK;
        end
        default: dec.op = EMPTY_INS;
      endcase
    end
    if (dec.op != EMPTY_INS) begin
      case (word[6:0])
        OPC_LUI, OPC_AUIPC: begin
          dec.rd  = {1'b0, word[11:7]};
          dec.imm = {word[31:12], 12'b0};
        end
        OPC_JAL: begin
          dec.rd  = {1'b0, word[11:7]};
          dec.imm = {{12{word[31]}}, word[19:12], word[20], word[30:21], 1'b0};
        end
        OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
          dec.rd  = {1'b0, word[11:7]};
          dec.rs1 = {1'b0, word[19:15]};
          dec.imm = (f3 == 3'b001 || f3 == 3'b101) && (word[6:0] == OPC_OPIMM)
                    ? {27'b0, word[24:20]} : {{20{word[31]}}, word[31:20]};
        end
        OPC_BRANCH: begin
          dec.rs1 = {1'b0, word[19:15]};
          dec.rs2 = {1'b0, word[24:20]};
          dec.imm = {{20{word[31]}}, word[7], word[30:25], word[11:8], 1'b0};
        end
        OPC_STORE: begin
          dec.rs1 = {1'b0, word[19:15]};
          dec.rs2 = {1'b0, word[24:20]};
          dec.imm = {{20{word[31]}}, word[31:25], word[11:7]};
        end
        OPC_OP: begin
          dec.rd  = {1'b0, word[11:7]};
          dec.rs1 = {1'b0, word[19:15]};
          dec.rs2 = {1'b0, word[24:20]};
        end
        default: ;
      endcase
    end
  end

  // FIFO storage and pointers.
  logic [DECODED_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]            count_q, count_d;
  logic                     full, empty, push, pop;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign in_ready  = rst_n_in && rdy_in && !full;
  assign out_valid = rdy_in && !empty;
  assign push      = in_valid && in_ready && !flush_in;
  assign pop       = out_valid && out_ready && !flush_in;

  // Next-state pointers and occupancy; flush empties regardless of handshakes.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_in) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  // Pointer/count registers; holding while rdy_in is low falls out of push/pop gating.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage written at the tail on push.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    // NOTE: entries are reset because the head drives out_* directly and must read EMPTY_INS/0 in reset.
    if (!rst_n_in) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= RESET_REC;
    end else if (push) begin
      mem_q[wr_ptr_q] <= dec;
    end
  end

  assign head     = decoded_t'(mem_q[rd_ptr_q]);
  assign out_type = head.op;
  assign out_rd   = head.rd;
  assign out_rs1  = head.rs1;
  assign out_rs2  = head.rs2;
  assign out_imm  = head.imm;
  assign out_pc   = head.pc;
  assign out_is_c = head.is_c;
  assign count    = count_q;

endmodule

// File: tb/tb_decode_queue.sv
// Directed self-checking bench for decode_queue (C_EXT=1 main DUT, C_EXT=0 shadow).
module tb_decode_queue;
  import decode_queue_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, rdy, flush, in_valid, out_ready;
  logic [31:0] in_code, in_pc;

  logic        in_ready, out_valid, out_is_c;
  logic [5:0]  out_type, out_rd, out_rs1, out_rs2;
  logic [31:0] out_imm, out_pc;
  logic [2:0]  count;

  logic        nc_in_ready, nc_out_valid, nc_out_is_c;
  logic [5:0]  nc_out_type, nc_out_rd, nc_out_rs1, nc_out_rs2;
  logic [31:0] nc_out_imm, nc_out_pc;
  logic [2:0]  nc_count;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  decode_queue #(.DEPTH(4), .C_EXT(1'b1)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy), .flush_in(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_type(out_type),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
    .out_pc(out_pc), .out_is_c(out_is_c), .count(count)
  );

  decode_queue #(.DEPTH(4), .C_EXT(1'b0)) dut_nc (
    .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy), .flush_in(flush),
    .in_valid(in_valid), .in_ready(nc_in_ready), .in_code(in_code), .in_pc(in_pc),
    .out_valid(nc_out_valid), .out_ready(out_ready), .out_type(nc_out_type),
    .out_rd(nc_out_rd), .out_rs1(nc_out_rs1), .out_rs2(nc_out_rs2), .out_imm(nc_out_imm),
    .out_pc(nc_out_pc), .out_is_c(nc_out_is_c), .count(nc_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] code, input logic [31:0] pc);
    in_valid = 1'b1;
    in_code  = code;
    in_pc    = pc;
    step();
    in_valid = 1'b0;
  endtask

  task automatic check_head(input string tag, input op_e op, input logic [5:0] rd,
                            input logic [5:0] rs1, input logic [5:0] rs2,
                            input logic [31:0] imm, input logic [31:0] pc, input logic is_c);
    check({tag, ".valid"}, out_valid, 1'b1);
    check({tag, ".type"},  out_type,  op);
    check({tag, ".rd"},    out_rd,    rd);
    check({tag, ".rs1"},   out_rs1,   rs1);
    check({tag, ".rs2"},   out_rs2,   rs2);
    check({tag, ".imm"},   out_imm,   imm);
    check({tag, ".pc"},    out_pc,    pc);
    check({tag, ".is_c"},  out_is_c,  is_c);
  endtask

  initial begin
    // NOTE: bench drives inputs with blocking assignments, away from the sampling edge.
    rst_n = 1'b0; rdy = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_code = '0; in_pc = '0;
    #3;
    check("rst.count",    count,     0);
    check("rst.valid",    out_valid, 0);
    check("rst.in_ready", in_ready,  0);
    check("rst.type",     out_type,  EMPTY_INS);
    check("rst.rd",       out_rd,    0);
    check("rst.imm",      out_imm,   0);
    check("rst.pc",       out_pc,    0);
    #9;
    rst_n = 1'b1;

    // Basic decode, streaming with out_ready held high.
    out_ready = 1'b1;
    push(32'h0050_0093, 32'h100);
    check_head("addi", OP_ADDI, 6'd1, 6'd0, 6'd32, 32'd5, 32'h100, 1'b0);
    check("addi.count", count, 1);
    push(32'h4033_5293, 32'h104);
    check_head("srai", OP_SRAI, 6'd5, 6'd6, 6'd32, 32'd3, 32'h104, 1'b0);
    check("srai.count", count, 1);
    push(32'h0000_557D, 32'h108);
    check_head("c.li", OP_ADDI, 6'd10, 6'd0, 6'd32, 32'hFFFF_FFFF, 32'h108, 1'b1);
    check("c.li.noc.type", nc_out_type, EMPTY_INS);
    check("c.li.noc.rd",   nc_out_rd,   32);
    push(32'h0000_40C0, 32'h10A);
    check_head("c.lw", OP_LW, 6'd8, 6'd9, 6'd32, 32'd4, 32'h10A, 1'b1);
    push(32'h0000_C401, 32'h10C);
    check_head("c.beqz", OP_BEQ, 6'd32, 6'd8, 6'd0, 32'd8, 32'h10C, 1'b1);
    push(32'h0000_0000, 32'h10E);
    check_head("c.zero", EMPTY_INS, 6'd32, 6'd32, 6'd32, 32'd0, 32'h10E, 1'b1);
    step();
    check("drain0.count", count, 0);
    check("drain0.valid", out_valid, 0);

    // Fill to capacity, try an extra push, then drain in order.
    out_ready = 1'b0;
    push(32'h0020_8463, 32'h200);
    push(32'h0020_A223, 32'h204);
    push(32'h0050_0093, 32'h208);
    push(32'h1234_50B7, 32'h20C);
    check("full.count",    count,    4);
    check("full.in_ready", in_ready, 0);
    check_head("beq", OP_BEQ, 6'd32, 6'd1, 6'd2, 32'd8, 32'h200, 1'b0);
    push(32'h0010_0093, 32'h210);
    check("full.reject.count", count, 4);
    out_ready = 1'b1;
    step();
    check("drain.count3", count, 3);
    check_head("sw", OP_SW, 6'd32, 6'd1, 6'd2, 32'd4, 32'h204, 1'b0);
    step();
    check("drain.count2", count, 2);
    check("drain.pc2", out_pc, 32'h208);
    step();
    check("drain.count1", count, 1);
    check_head("lui", OP_LUI, 6'd1, 6'd32, 6'd32, 32'h1234_5000, 32'h20C, 1'b0);
    step();
    check("drain.count0", count, 0);
    check("drain.valid0", out_valid, 0);

    // Flush wins over a same-cycle push and pop.
    out_ready = 1'b0;
    push(32'h0050_0093, 32'h400);
    push(32'h0050_0093, 32'h404);
    push(32'h0050_0093, 32'h408);
    check("flush.pre.count", count, 3);
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_code = 32'h0050_0093; in_pc = 32'h40C;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("flush.count",    count,     0);
    check("flush.valid",    out_valid, 0);
    check("flush.in_ready", in_ready,  1);
    step();
    check("flush.lost.count", count, 0);

    // Freeze with rdy low.
    push(32'h0050_0093, 32'h300);
    push(32'h0050_0093, 32'h304);
    check("frz.pre.count", count, 2);
    rdy = 1'b0; in_valid = 1'b1; out_ready = 1'b1; in_code = 32'h0010_0093; in_pc = 32'h308;
    step();
    check("frz.count",    count,     2);
    check("frz.valid",    out_valid, 0);
    check("frz.in_ready", in_ready,  0);
    in_valid = 1'b0; out_ready = 1'b0; rdy = 1'b1;
    #1;
    check("frz.resume.valid", out_valid, 1);
    check("frz.resume.pc",    out_pc,    32'h300);

    // Asynchronous reset between edges, then push on the first edge after release.
    rst_n = 1'b0;
    #1;
    check("arst.count",    count,     0);
    check("arst.valid",    out_valid, 0);
    check("arst.in_ready", in_ready,  0);
    check("arst.type",     out_type,  EMPTY_INS);
    rst_n = 1'b1;
    #1;
    push(32'h0050_0093, 32'h500);
    check("post.count", count, 1);
    check("post.pc",    out_pc, 32'h500);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
